// File: rtl/calc_pkg.sv
// Shared constants for the calculator core: opcodes, one-hot state encoding and
// Flag bit positions.
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int S_I      = 0;
  localparam int S_GET_A  = 1;
  localparam int S_GET_B  = 2;
  localparam int S_GET_OP = 3;
  localparam int S_ADD    = 4;
  localparam int S_SUB    = 5;
  localparam int S_MUL    = 6;
  localparam int S_DIV    = 7;
  localparam int S_ERR    = 8;
  localparam int S_DONE   = 9;
  localparam int NUM_ST   = 10;

  localparam int FLG_CARRY = 0;
  localparam int FLG_OVF   = 1;
  localparam int FLG_DZ    = 2;

  // Each state value is a single bit at its S_* index, so state bits map straight to outputs.
  typedef enum logic [NUM_ST-1:0] {
    ST_I      = 10'b00_0000_0001,
    ST_GET_A  = 10'b00_0000_0010,
    ST_GET_B  = 10'b00_0000_0100,
    ST_GET_OP = 10'b00_0000_1000,
    ST_ADD    = 10'b00_0001_0000,
    ST_SUB    = 10'b00_0010_0000,
    ST_MUL    = 10'b00_0100_0000,
    ST_DIV    = 10'b00_1000_0000,
    ST_ERR    = 10'b01_0000_0000,
    ST_DONE   = 10'b10_0000_0000
  } state_e;

endpackage

// File: rtl/calc_seq_div.sv
// Start/busy/done divider by repeated subtraction; holds working remainder R and quotient Q.
// The o_rem port exists only when CALC_REM_EN is defined.
module calc_seq_div #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quot
`ifdef CALC_REM_EN
  ,
  output logic [WIDTH-1:0] o_rem
`endif
);

  logic             r_busy;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;
  logic             w_ge;

  // i_b must stay stable while busy; the caller never starts with i_b == 0.
  assign w_ge = (r_rem >= i_b);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_busy <= 1'b0;
      r_rem  <= '0;
      r_quot <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_rem  <= i_a;
      r_quot <= '0;
    end else if (r_busy) begin
      if (w_ge) begin
        r_rem  <= r_rem - i_b;
        r_quot <= r_quot + WIDTH'(1);
      end else begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_done = r_busy & ~w_ge;
  assign o_quot = r_quot;
`ifdef CALC_REM_EN
  assign o_rem  = r_rem;
`endif

endmodule

// File: rtl/ee354_calc_core.sv
// Calculator core: captures A, B and an opcode on Confirm pulses, then adds, subtracts,
// multiplies (shift-add) or divides (calc_seq_div). CALC_REM_EN builds the Remainder register.
module ee354_calc_core
  import calc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Input,
  input  logic             Confirm,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Remainder,
  output logic [WIDTH-1:0] Flag,
  output logic             QI,
  output logic             QGet_A,
  output logic             QGet_B,
  output logic             QGet_Op,
  output logic             QAdd,
  output logic             QSub,
  output logic             QMul,
  output logic             QDiv,
  output logic             QErr,
  output logic             QDone,
  output logic             Done
);

  state_e             r_state;
  state_e             w_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_flag;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [2*WIDTH-1:0] w_prod_next;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH:0]     w_sum;
  logic [1:0]         w_op;
  logic               w_mul_last;
  logic               w_mul_start;
  logic               w_div_start;
  logic               w_dz;
  logic               w_div_done;
  logic [WIDTH-1:0]   w_div_quot;

  assign w_op        = Input[1:0];
  assign w_sum       = {1'b0, r_a} + {1'b0, r_b};
  assign w_prod_next = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
  assign w_mul_last  = (r_cnt == CNT_W'(WIDTH - 1));

  // Confirm is a one-cycle pulse; it is consumed only in QGet_A/QGet_B/QGet_Op/QErr/QDone
  // and silently dropped in every other state (no queuing).
  always_comb begin
    w_next      = r_state;
    w_mul_start = 1'b0;
    w_div_start = 1'b0;
    w_dz        = 1'b0;
    case (r_state)
      ST_I:      w_next = ST_GET_A;
      ST_GET_A:  if (Confirm) w_next = ST_GET_B;
      ST_GET_B:  if (Confirm) w_next = ST_GET_OP;
      ST_GET_OP: begin
        if (Confirm) begin
          case (w_op)
            OP_ADD: w_next = ST_ADD;
            OP_SUB: w_next = ST_SUB;
            OP_MUL: begin
              w_next      = ST_MUL;
              w_mul_start = 1'b1;
            end
            default: begin
              if (r_b == '0) begin
                w_next = ST_ERR;
                w_dz   = 1'b1;
              end else begin
                w_next      = ST_DIV;
                w_div_start = 1'b1;
              end
            end
          endcase
        end
      end
      ST_ADD, ST_SUB: w_next = ST_DONE;
      ST_MUL:    if (w_mul_last) w_next = ST_DONE;
      ST_DIV:    if (w_div_done) w_next = ST_DONE;
      ST_ERR, ST_DONE: if (Confirm) w_next = ST_I;
      default:   w_next = ST_I;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= ST_I;
    else        r_state <= w_next;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_flag   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_I: begin
          r_a      <= '0;
          r_b      <= '0;
          r_result <= '0;
          r_flag   <= '0;
        end
        ST_GET_A: if (Confirm) r_a <= Input;
        ST_GET_B: if (Confirm) r_b <= Input;
        ST_GET_OP: begin
          if (w_mul_start) begin
            r_prod   <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, r_a};
            r_mplier <= r_b;
            r_cnt    <= '0;
          end
          if (w_dz) begin
            r_result       <= '0;
            r_flag         <= '0;
            r_flag[FLG_DZ] <= 1'b1;
          end
        end
        ST_ADD: begin
          r_result          <= w_sum[WIDTH-1:0];
          r_flag            <= '0;
          r_flag[FLG_CARRY] <= w_sum[WIDTH];
        end
        ST_SUB: begin
          r_result          <= r_a - r_b;
          r_flag            <= '0;
          r_flag[FLG_CARRY] <= (r_a < r_b);
        end
        ST_MUL: begin
          r_prod   <= w_prod_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_mul_last) begin
            r_result        <= w_prod_next[WIDTH-1:0];
            r_flag          <= '0;
            r_flag[FLG_OVF] <= |w_prod_next[2*WIDTH-1:WIDTH];
          end
        end
        ST_DIV: if (w_div_done) r_result <= w_div_quot;
        default: ;
      endcase
    end
  end

`ifdef CALC_REM_EN
  logic [WIDTH-1:0] w_div_rem;
  logic [WIDTH-1:0] r_rem;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                                r_rem <= '0;
    else if (r_state == ST_I)                  r_rem <= '0;
    else if (r_state == ST_DIV && w_div_done)  r_rem <= w_div_rem;
  end

  assign Remainder = r_rem;
`else
  assign Remainder = '0;
`endif

  calc_seq_div #(.WIDTH(WIDTH)) u_div (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_start (w_div_start),
    .i_a     (r_a),
    .i_b     (r_b),
    .o_done  (w_div_done),
    .o_quot  (w_div_quot)
`ifdef CALC_REM_EN
    ,
    .o_rem   (w_div_rem)
`endif
  );

  assign A       = r_a;
  assign B       = r_b;
  assign Result  = r_result;
  assign Flag    = r_flag;
  assign QI      = r_state[S_I];
  assign QGet_A  = r_state[S_GET_A];
  assign QGet_B  = r_state[S_GET_B];
  assign QGet_Op = r_state[S_GET_OP];
  assign QAdd    = r_state[S_ADD];
  assign QSub    = r_state[S_SUB];
  assign QMul    = r_state[S_MUL];
  assign QDiv    = r_state[S_DIV];
  assign QErr    = r_state[S_ERR];
  assign QDone   = r_state[S_DONE];
  assign Done    = r_state[S_DONE] | r_state[S_ERR];

endmodule

// File: tb/tb_ee354_calc_core.sv
// Bench for ee354_calc_core: directed cases, random operations with stray Confirm pulses,
// and an asynchronous reset in the middle of a division.
`timescale 1ns/1ps
module tb_ee354_calc_core;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;
  localparam int unsigned MASK = (32'd1 << WIDTH) - 1;
  localparam int CYC_LIMIT = 70000;
`ifdef CALC_REM_EN
  localparam bit REM_EN = 1'b1;
`else
  localparam bit REM_EN = 1'b0;
`endif

  // State vector in the order the states are listed: bit0 QI ... bit9 QDone.
  localparam logic [9:0] T_I    = 10'h001;
  localparam logic [9:0] T_GA   = 10'h002;
  localparam logic [9:0] T_DIV  = 10'h080;
  localparam logic [9:0] T_ERR  = 10'h100;
  localparam logic [9:0] T_DONE = 10'h200;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             Confirm = 1'b0;
  logic [WIDTH-1:0] Input = '0;
  logic [WIDTH-1:0] A, B, Result, Remainder, Flag;
  logic QI, QGet_A, QGet_B, QGet_Op, QAdd, QSub, QMul, QDiv, QErr, QDone, Done;
  logic [9:0] w_q;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  assign w_q = {QDone, QErr, QDiv, QMul, QSub, QAdd, QGet_Op, QGet_B, QGet_A, QI};

  ee354_calc_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .Input(Input), .Confirm(Confirm),
    .A(A), .B(B), .Result(Result), .Remainder(Remainder), .Flag(Flag),
    .QI(QI), .QGet_A(QGet_A), .QGet_B(QGet_B), .QGet_Op(QGet_Op), .QAdd(QAdd),
    .QSub(QSub), .QMul(QMul), .QDiv(QDiv), .QErr(QErr), .QDone(QDone), .Done(Done)
  );

  // Clock / reset
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pushes result, flag, remainder, cycles, final state.
  task automatic model_op(input int unsigned a, input int unsigned b, input int op);
    int unsigned res, flg, rem, cyc;
    logic [9:0] fin;
    longint unsigned p;
    rem = 0;
    fin = T_DONE;
    case (op)
      0: begin
        res = (a + b) & MASK;
        flg = ((a + b) > MASK) ? 1 : 0;
        cyc = 1;
      end
      1: begin
        res = (a - b) & MASK;
        flg = (a < b) ? 1 : 0;
        cyc = 1;
      end
      2: begin
        p   = longint'(a) * longint'(b);
        res = int'(p & MASK);
        flg = (p > MASK) ? 2 : 0;
        cyc = WIDTH;
      end
      default: begin
        if (b == 0) begin
          res = 0; flg = 4; cyc = 0; fin = T_ERR;
        end else begin
          res = a / b;
          flg = 0;
          rem = REM_EN ? (a % b) : 0;
          cyc = a / b + 1;
        end
      end
    endcase
    exp_q.push_back(res);
    exp_q.push_back(flg);
    exp_q.push_back(rem);
    exp_q.push_back(cyc);
    exp_q.push_back(32'(fin));
  endtask

  // Drivers (called on a falling edge, return on a falling edge)
  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic pulse(input logic [WIDTH-1:0] v);
    Input = v;
    Confirm = 1'b1;
    step();
    Confirm = 1'b0;
  endtask

  task automatic wait_state(input logic [9:0] s);
    int n = 0;
    while (w_q !== s && n < 8) begin
      step();
      n++;
    end
    check("wait_state", w_q, s);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int op, input bit noise);
    int cyc;
    logic [WIDTH-1:0] opw;
    logic [31:0] e_res, e_flg, e_rem, e_cyc, e_fin;
    model_op(a, b, op);
    wait_state(T_GA);
    pulse(a);
    pulse(b);
    opw = WIDTH'($urandom());
    opw[1:0] = op[1:0];
    pulse(opw);
    cyc = 0;
    while (!Done && cyc < CYC_LIMIT) begin
      cyc++;
      if (noise && $urandom_range(0, 3) == 0) begin
        Input = WIDTH'($urandom());
        Confirm = 1'b1;
      end
      step();
      Confirm = 1'b0;
    end
    e_res = exp_q.pop_front();
    e_flg = exp_q.pop_front();
    e_rem = exp_q.pop_front();
    e_cyc = exp_q.pop_front();
    e_fin = exp_q.pop_front();
    check("cycles", cyc, e_cyc);
    check("result", Result, e_res);
    check("flag", Flag, e_flg);
    check("remainder", Remainder, e_rem);
    check("final_state", w_q, e_fin);
    check("done", Done, 1);
    check("opA", A, a);
    check("opB", B, b);
    repeat (2) step();
    check("hold_result", Result, e_res);
    check("hold_state", w_q, e_fin);
    pulse(WIDTH'($urandom()));
    check("to_qi", w_q, T_I);
    step();
    check("cleared", 32'(A | B | Result | Flag | Remainder), 0);
    check("to_get_a", w_q, T_GA);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int op;
    logic [WIDTH-1:0] ra, rb;
    #1 Reset = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_state", w_q, T_I);
    check("rst_outs", 32'(A | B | Result | Flag | Remainder), 0);
    check("rst_done", Done, 0);
    Reset = 1'b1;
    step();
    check("qi_to_get_a", w_q, T_GA);

    run_op(16'h0012, 16'h0034, 0, 1'b0);
    run_op(16'h0005, 16'h0007, 1, 1'b0);
    run_op(16'h0100, 16'h0100, 2, 1'b0);
    run_op(16'h0064, 16'h0007, 3, 1'b0);
    run_op(16'h1234, 16'h0000, 3, 1'b0);
    run_op(16'hFFFF, 16'h0001, 0, 1'b0);
    run_op(16'h0008, 16'h0008, 1, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 2, 1'b0);
    run_op(16'h0000, 16'h0000, 2, 1'b0);
    run_op(16'h0006, 16'h0007, 3, 1'b0);
    run_op(16'h000E, 16'h0007, 3, 1'b0);

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      ra = WIDTH'($urandom());
      rb = WIDTH'($urandom());
      if (op == 3) begin
        case ($urandom_range(0, 3))
          0: rb = '0;
          1: begin
            rb = WIDTH'($urandom_range(1, 15));
            ra = WIDTH'($urandom_range(0, 300));
          end
          default: rb = WIDTH'($urandom_range(256, 65535));
        endcase
      end
      run_op(ra, rb, op, 1'b1);
    end

    // Reset in the middle of a division, with Confirm pulses arriving during QDiv.
    wait_state(T_GA);
    pulse(16'h0064);
    pulse(16'h0007);
    pulse(16'hA5A7);
    check("in_div", w_q, T_DIV);
    repeat (4) begin
      Confirm = 1'b1;
      step();
      Confirm = 1'b0;
    end
    check("div_ignores_confirm", w_q, T_DIV);
    #2 Reset = 1'b0;
    #1;
    check("async_rst_state", w_q, T_I);
    check("async_rst_outs", 32'(A | B | Result | Flag | Remainder), 0);
    check("async_rst_done", Done, 0);
    repeat (3) @(negedge Clk);
    check("rst_hold", w_q, T_I);
    Reset = 1'b1;
    step();
    check("restart", w_q, T_GA);
    run_op(16'h0012, 16'h0034, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
